// File: rtl/i_cache_pkg.sv
// Shared geometry for the direct-mapped instruction cache: widths, address
// field positions and the line-base helper.
package i_cache_pkg;

    localparam int VIRT_ADDR_WIDTH         = 32;
    localparam int ICACHE_NLINES           = 4;
    localparam int ICACHE_LINE_WIDTH       = 128;
    localparam int ICACHE_BYTEINLINE_WIDTH = 4;
    localparam int ICACHE_INDEX_WIDTH      = 2;
    localparam int ICACHE_TAG_WIDTH        = 26;

    localparam int WORD_WIDTH      = 32;
    localparam int WORDS_PER_LINE  = ICACHE_LINE_WIDTH / WORD_WIDTH;
    localparam int WORD_SEL_WIDTH  = 2;

    // Address field bit positions: tag | index | word | byte
    localparam int WORD_LSB  = 2;
    localparam int WORD_MSB  = WORD_LSB + WORD_SEL_WIDTH - 1;
    localparam int INDEX_LSB = ICACHE_BYTEINLINE_WIDTH;
    localparam int INDEX_MSB = INDEX_LSB + ICACHE_INDEX_WIDTH - 1;
    localparam int TAG_LSB   = INDEX_LSB + ICACHE_INDEX_WIDTH;
    localparam int TAG_MSB   = VIRT_ADDR_WIDTH - 1;

    function automatic logic [VIRT_ADDR_WIDTH-1:0] line_base(
        input logic [VIRT_ADDR_WIDTH-1:0] a
    );
        return {a[VIRT_ADDR_WIDTH-1:ICACHE_BYTEINLINE_WIDTH], {ICACHE_BYTEINLINE_WIDTH{1'b0}}};
    endfunction

endpackage

// File: rtl/i_cache_imem.sv
// Combinational instruction ROM: every aligned word holds its own byte address,
// so a line is the four consecutive word addresses starting at its base.
module imem_rom
    import i_cache_pkg::*;
(
    input  logic [VIRT_ADDR_WIDTH-1:0]   line_base,
    output logic [ICACHE_LINE_WIDTH-1:0] line
);

    for (genvar w = 0; w < WORDS_PER_LINE; w++) begin : g_word
        assign line[w*WORD_WIDTH +: WORD_WIDTH] = line_base + VIRT_ADDR_WIDTH'(4 * w);
    end

endmodule

// File: rtl/i_cache.sv
// Direct-mapped read-only instruction cache. Lookup is combinational; a miss
// with wrt_en set allocates the line from the ROM at the next rising edge.
module i_cache
    import i_cache_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wrt_en,
    input  logic [VIRT_ADDR_WIDTH-1:0] addr,
    output logic [WORD_WIDTH-1:0]      instr,
    output logic                       cache_hit
);

    logic [ICACHE_TAG_WIDTH-1:0]   tag_arr  [ICACHE_NLINES];
    logic [ICACHE_LINE_WIDTH-1:0]  data_arr [ICACHE_NLINES];
    logic [ICACHE_NLINES-1:0]      valid;

    logic [ICACHE_TAG_WIDTH-1:0]   addr_tag;
    logic [ICACHE_INDEX_WIDTH-1:0] idx;
    logic [WORD_SEL_WIDTH-1:0]     word;
    logic [ICACHE_LINE_WIDTH-1:0]  rom_line;
    logic                          fill;
    logic                          unused_addr;

    assign addr_tag    = addr[TAG_MSB:TAG_LSB];
    assign idx         = addr[INDEX_MSB:INDEX_LSB];
    assign word        = addr[WORD_MSB:WORD_LSB];
    assign unused_addr = ^addr[WORD_LSB-1:0];

    imem_rom u_rom (
        .line_base (line_base(addr)),
        .line      (rom_line)
    );

    assign cache_hit = valid[idx] && (tag_arr[idx] == addr_tag);
    assign instr     = cache_hit ? data_arr[idx][{word, 5'b0} +: WORD_WIDTH] : '0;
    assign fill      = wrt_en && !cache_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            valid <= '0;
        else if (fill)
            valid[idx] <= 1'b1;
    end

    // Data/tag are not reset and may be written while reset is held; that is
    // harmless because the line stays invalid until a later fill rewrites it.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_arr[idx] <= rom_line;
            tag_arr[idx]  <= addr_tag;
        end
    end

endmodule

// File: tb/tb_i_cache.sv
// Scoreboard bench for i_cache: expected {hit, instr} pairs are queued per
// scenario and compared as each address is presented.
module tb_i_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic        wrt_en;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        cache_hit;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] a;
        logic        hit;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];

    i_cache dut (
        .clk       (clk),
        .reset     (reset),
        .wrt_en    (wrt_en),
        .addr      (addr),
        .instr     (instr),
        .cache_hit (cache_hit)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [31:0] a, input logic h, input logic [31:0] i);
        sb.push_back('{a: a, hit: h, ins: i});
    endtask

    task automatic fill(input logic [31:0] a);
        @(negedge clk);
        addr   = a;
        wrt_en = 1'b1;
        @(posedge clk);
        #1;
        wrt_en = 1'b0;
    endtask

    task automatic test_reset;
        exp_t e;
        reset = 1'b0; wrt_en = 1'b0; addr = 32'h50;
        #3;
        checks++;
        if ({cache_hit, instr} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_held hit=%b instr=%h want hit=0 instr=0", cache_hit, instr);
        end
        // fill attempt while reset is held must not allocate
        @(negedge clk); wrt_en = 1'b1;
        @(posedge clk); #1; wrt_en = 1'b0;
        @(negedge clk); reset = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        push(32'h50, 1'b0, 32'h0);
        push(32'h00, 1'b0, 32'h0);
        push(32'h5C, 1'b0, 32'h0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            addr = e.a; #1;
            checks++;
            if ({cache_hit, instr} !== {e.hit, e.ins}) begin
                errors++;
                $display("FAIL reset_release addr=%h hit=%b instr=%h want hit=%b instr=%h",
                         e.a, cache_hit, instr, e.hit, e.ins);
            end
        end
    endtask

    task automatic test_fill;
        exp_t e;
        fill(32'h50);
        push(32'h50, 1'b1, 32'h50);
        push(32'h51, 1'b1, 32'h50);
        push(32'h52, 1'b1, 32'h50);
        push(32'h53, 1'b1, 32'h50);
        push(32'h54, 1'b1, 32'h54);
        push(32'h5A, 1'b1, 32'h58);
        push(32'h5C, 1'b1, 32'h5C);
        push(32'h60, 1'b0, 32'h0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            addr = e.a; #1;
            checks++;
            if ({cache_hit, instr} !== {e.hit, e.ins}) begin
                errors++;
                $display("FAIL fill addr=%h hit=%b instr=%h want hit=%b instr=%h",
                         e.a, cache_hit, instr, e.hit, e.ins);
            end
        end
    endtask

    task automatic test_conflict;
        exp_t e;
        @(negedge clk); addr = 32'h000F0050; wrt_en = 1'b0;
        @(posedge clk); #1;
        push(32'h000F0050, 1'b0, 32'h0);
        push(32'h00000050, 1'b1, 32'h50);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            addr = e.a; #1;
            checks++;
            if ({cache_hit, instr} !== {e.hit, e.ins}) begin
                errors++;
                $display("FAIL conflict_nofill addr=%h hit=%b instr=%h want hit=%b instr=%h",
                         e.a, cache_hit, instr, e.hit, e.ins);
            end
        end
        fill(32'h000F0050);
        push(32'h000F0050, 1'b1, 32'h000F0050);
        push(32'h000F005C, 1'b1, 32'h000F005C);
        push(32'h00000050, 1'b0, 32'h0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            addr = e.a; #1;
            checks++;
            if ({cache_hit, instr} !== {e.hit, e.ins}) begin
                errors++;
                $display("FAIL conflict_evict addr=%h hit=%b instr=%h want hit=%b instr=%h",
                         e.a, cache_hit, instr, e.hit, e.ins);
            end
        end
    endtask

    task automatic test_index0_seq;
        exp_t e;
        logic [31:0] seq [3];
        seq[0] = 32'hF0000000; seq[1] = 32'hFFFFFFC0; seq[2] = 32'h00000043;
        for (int k = 0; k < 3; k++) begin
            fill(seq[k]);
            push(seq[k], 1'b1, {seq[k][31:2], 2'b00});
            push({seq[k][31:4], 4'hF}, 1'b1, {seq[k][31:4], 4'hC});
            if (k > 0) push(seq[k-1], 1'b0, 32'h0);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                addr = e.a; #1;
                checks++;
                if ({cache_hit, instr} !== {e.hit, e.ins}) begin
                    errors++;
                    $display("FAIL index0_seq addr=%h hit=%b instr=%h want hit=%b instr=%h",
                             e.a, cache_hit, instr, e.hit, e.ins);
                end
            end
        end
    endtask

    task automatic test_all_lines;
        exp_t e;
        for (int k = 0; k < 4; k++) fill(32'(k * 16));
        push(32'h00, 1'b1, 32'h00);
        push(32'h10, 1'b1, 32'h10);
        push(32'h20, 1'b1, 32'h20);
        push(32'h30, 1'b1, 32'h30);
        push(32'h14, 1'b1, 32'h14);
        push(32'h3C, 1'b1, 32'h3C);
        push(32'h40, 1'b0, 32'h0);
        push(32'h000F0050, 1'b0, 32'h0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            addr = e.a; #1;
            checks++;
            if ({cache_hit, instr} !== {e.hit, e.ins}) begin
                errors++;
                $display("FAIL all_lines addr=%h hit=%b instr=%h want hit=%b instr=%h",
                         e.a, cache_hit, instr, e.hit, e.ins);
            end
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        @(posedge clk); #1;
        addr = 32'h20; #1;
        checks++;
        if ({cache_hit, instr} !== {1'b1, 32'h20}) begin
            errors++;
            $display("FAIL pre_reset hit=%b instr=%h want hit=1 instr=00000020", cache_hit, instr);
        end
        reset = 1'b0; #1;
        checks++;
        if ({cache_hit, instr} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL async_reset hit=%b instr=%h want hit=0 instr=0", cache_hit, instr);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        push(32'h50, 1'b0, 32'h0);
        push(32'h00, 1'b0, 32'h0);
        push(32'h30, 1'b0, 32'h0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            addr = e.a; #1;
            checks++;
            if ({cache_hit, instr} !== {e.hit, e.ins}) begin
                errors++;
                $display("FAIL after_reset addr=%h hit=%b instr=%h want hit=%b instr=%h",
                         e.a, cache_hit, instr, e.hit, e.ins);
            end
        end
        fill(32'h58);
        push(32'h50, 1'b1, 32'h50);
        push(32'h58, 1'b1, 32'h58);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            addr = e.a; #1;
            checks++;
            if ({cache_hit, instr} !== {e.hit, e.ins}) begin
                errors++;
                $display("FAIL refill addr=%h hit=%b instr=%h want hit=%b instr=%h",
                         e.a, cache_hit, instr, e.hit, e.ins);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_conflict();
        test_index0_seq();
        test_all_lines();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
